// File: rtl/gameover_arrow_ctrl.sv
// Game-over restart arrow sequencer: input lockout, blinking arrow while
// waiting, button hold qualification and a one-cycle restart request.
module gameover_arrow_ctrl #(
  parameter int unsigned LOCK_FRAMES  = 30,
  parameter int unsigned BLINK_FRAMES = 15,
  parameter int unsigned HOLD_FRAMES  = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       game_over,
  input  logic       btn,
  input  logic       arrow_px,
  output logic       arrow_on,
  output logic       arrow_visible,
  output logic       restart,
  output logic [2:0] state
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned ST_W  = 3;

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);

  typedef enum logic [ST_W-1:0] {
    ST_PLAY    = 3'd0,
    ST_LOCK    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RESTART = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic             btn_q;
  logic             arrow_visible_q, arrow_visible_d;
  logic             restart_q, restart_d;

  logic             btn_rise;
  logic [CNT_W-1:0] cnt_inc;
  logic             lock_term;
  logic             blink_term;
  logic             hold_term;

  // Button edge and terminal-frame detection
  always_comb begin
    btn_rise   = btn & ~btn_q;
    cnt_inc    = cnt_q + CNT_W'(1);
    lock_term  = frame_tick && (cnt_q == LOCK_LAST);
    blink_term = frame_tick && (cnt_q == BLINK_LAST);
    hold_term  = frame_tick && (cnt_q == HOLD_LAST);
  end

  // Next-state, frame counter, blink phase and registered output decode
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    blink_phase_d = blink_phase_q;

    unique case (state_q)
      ST_PLAY: begin
        if (game_over) begin
          state_d = ST_LOCK;
          cnt_d   = '0;
        end
      end
      ST_LOCK: begin
        if (!game_over) begin
          state_d = ST_PLAY;
          cnt_d   = '0;
        end else if (lock_term) begin
          state_d       = ST_WAIT;
          cnt_d         = '0;
          blink_phase_d = 1'b1;
        end else if (frame_tick) begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT: begin
        if (!game_over) begin
          state_d = ST_PLAY;
          cnt_d   = '0;
        end else if (btn_rise) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (blink_term) begin
          blink_phase_d = ~blink_phase_q;
          cnt_d         = '0;
        end else if (frame_tick) begin
          cnt_d = cnt_inc;
        end
      end
      ST_HOLD: begin
        if (!game_over) begin
          state_d = ST_PLAY;
          cnt_d   = '0;
        end else if (!btn) begin
          // Release beats a coincident terminal tick
          state_d       = ST_WAIT;
          cnt_d         = '0;
          blink_phase_d = 1'b1;
        end else if (hold_term) begin
          state_d = ST_RESTART;
          cnt_d   = '0;
        end else if (frame_tick) begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESTART: begin
        state_d = ST_PLAY;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_PLAY;
        cnt_d   = '0;
      end
    endcase

    // Decoded from next state so the flops track the state register exactly
    arrow_visible_d = (state_d == ST_HOLD) || ((state_d == ST_WAIT) && blink_phase_d);
    restart_d       = (state_d == ST_RESTART);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_PLAY;
      cnt_q           <= '0;
      blink_phase_q   <= 1'b1;
      btn_q           <= 1'b0;
      arrow_visible_q <= 1'b0;
      restart_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      blink_phase_q   <= blink_phase_d;
      btn_q           <= btn;
      arrow_visible_q <= arrow_visible_d;
      restart_q       <= restart_d;
    end
  end

  // Output wiring; arrow_on stays combinational to add no pixel latency
  assign arrow_visible = arrow_visible_q;
  assign restart       = restart_q;
  assign state         = state_q;
  assign arrow_on      = arrow_px & arrow_visible_q;

endmodule

// File: tb/tb_gameover_arrow_ctrl.sv
// Directed bench for gameover_arrow_ctrl with short frame parameters.
module tb_gameover_arrow_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       game_over;
  logic       btn;
  logic       arrow_px;
  logic       arrow_on;
  logic       arrow_visible;
  logic       restart;
  logic [2:0] state;

  int checks;
  int errors;

  gameover_arrow_ctrl #(
    .LOCK_FRAMES (4),
    .BLINK_FRAMES(2),
    .HOLD_FRAMES (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .game_over    (game_over),
    .btn          (btn),
    .arrow_px     (arrow_px),
    .arrow_on     (arrow_on),
    .arrow_visible(arrow_visible),
    .restart      (restart),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given frame_tick value; returns 1 time unit after the edge
  task automatic cyc(input logic t);
    frame_tick = t;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  // One video frame: 9 idle clocks then the tick clock
  task automatic frame();
    repeat (9) cyc(1'b0);
    cyc(1'b1);
  endtask

  // Drive from PLAY through the whole lockout into WAIT with btn held
  task automatic enter_wait();
    game_over = 1'b1;
    btn       = 1'b1;
    cyc(1'b0);
    repeat (4) frame();
  endtask

  // WAIT -> HOLD via a fresh button press
  task automatic press();
    btn = 1'b0;
    cyc(1'b0);
    btn = 1'b1;
    cyc(1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (arrow_visible !== 1'b0) begin errors++; $display("FAIL reset_vis got %b exp 0", arrow_visible); end
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL reset_restart got %b exp 0", restart); end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      btn = i[0];
      cyc((i % 10) == 9);
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL play_state cyc %0d got %0d exp 0", i, state); end
      checks++; if (restart !== 1'b0) begin errors++; $display("FAIL play_restart cyc %0d got %b exp 0", i, restart); end
    end
  endtask

  task automatic test_lock_blink();
    logic [5:0] pat;
    pat = 6'b110011;
    btn       = 1'b1;
    game_over = 1'b1;
    cyc(1'b0);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL lock_entry got %0d exp 1", state); end
    checks++; if (arrow_visible !== 1'b0) begin errors++; $display("FAIL lock_vis got %b exp 0", arrow_visible); end
    for (int f = 0; f < 4; f++) begin
      repeat (5) cyc(1'b0);
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL lock_frame %0d state got %0d exp 1", f, state); end
      checks++; if (arrow_visible !== 1'b0) begin errors++; $display("FAIL lock_frame %0d vis got %b exp 0", f, arrow_visible); end
      repeat (4) cyc(1'b0);
      cyc(1'b1);
    end
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL wait_entry got %0d exp 2", state); end
    checks++; if (arrow_visible !== 1'b1) begin errors++; $display("FAIL wait_entry_vis got %b exp 1", arrow_visible); end
    for (int f = 0; f < 6; f++) begin
      repeat (5) cyc(1'b0);
      checks++; if (state !== 3'd2) begin errors++; $display("FAIL blink_frame %0d state got %0d exp 2", f, state); end
      checks++; if (arrow_visible !== pat[f]) begin errors++; $display("FAIL blink_frame %0d vis got %b exp %b", f, arrow_visible, pat[f]); end
      repeat (4) cyc(1'b0);
      cyc(1'b1);
    end
  endtask

  task automatic test_hold_restart();
    btn = 1'b0;
    cyc(1'b0);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL release_in_wait got %0d exp 2", state); end
    btn = 1'b1;
    cyc(1'b0);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL hold_entry got %0d exp 3", state); end
    checks++; if (arrow_visible !== 1'b1) begin errors++; $display("FAIL hold_vis got %b exp 1", arrow_visible); end
    arrow_px = 1'b1;
    #1;
    checks++; if (arrow_on !== 1'b1) begin errors++; $display("FAIL arrow_on_hit got %b exp 1", arrow_on); end
    arrow_px = 1'b0;
    #1;
    checks++; if (arrow_on !== 1'b0) begin errors++; $display("FAIL arrow_on_miss got %b exp 0", arrow_on); end
    frame();
    frame();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL hold_two_ticks got %0d exp 3", state); end
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL hold_early_restart got %b exp 0", restart); end
    frame();
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL restart_state got %0d exp 4", state); end
    checks++; if (restart !== 1'b1) begin errors++; $display("FAIL restart_pulse got %b exp 1", restart); end
    checks++; if (arrow_visible !== 1'b0) begin errors++; $display("FAIL restart_vis got %b exp 0", arrow_visible); end
    game_over = 1'b0;
    cyc(1'b0);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL after_restart got %0d exp 0", state); end
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL restart_width got %b exp 0", restart); end
    cyc(1'b0);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL play_stays got %0d exp 0", state); end
  endtask

  task automatic test_hold_release();
    enter_wait();
    frame();
    frame();
    checks++; if (arrow_visible !== 1'b0) begin errors++; $display("FAIL phase_low got %b exp 0", arrow_visible); end
    press();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL rel_hold_entry got %0d exp 3", state); end
    frame();
    frame();
    btn = 1'b0;
    cyc(1'b0);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL release_wait got %0d exp 2", state); end
    checks++; if (arrow_visible !== 1'b1) begin errors++; $display("FAIL release_phase got %b exp 1", arrow_visible); end
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL release_restart got %b exp 0", restart); end
    btn = 1'b1;
    cyc(1'b0);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL repress got %0d exp 3", state); end
    frame();
    frame();
    repeat (9) cyc(1'b0);
    btn = 1'b0;
    cyc(1'b1);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL tie_state got %0d exp 2", state); end
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL tie_restart got %b exp 0", restart); end
    cyc(1'b0);
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL tie_restart_late got %b exp 0", restart); end
  endtask

  task automatic test_game_over_drop();
    game_over = 1'b0;
    cyc(1'b0);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL drop_wait got %0d exp 0", state); end
    checks++; if (arrow_visible !== 1'b0) begin errors++; $display("FAIL drop_wait_vis got %b exp 0", arrow_visible); end
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL drop_wait_restart got %b exp 0", restart); end
    enter_wait();
    press();
    frame();
    game_over = 1'b0;
    cyc(1'b0);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL drop_hold got %0d exp 0", state); end
    checks++; if (arrow_visible !== 1'b0) begin errors++; $display("FAIL drop_hold_vis got %b exp 0", arrow_visible); end
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL drop_hold_restart got %b exp 0", restart); end
    cyc(1'b0);
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL drop_hold_late got %b exp 0", restart); end
  endtask

  task automatic test_async_reset();
    enter_wait();
    press();
    frame();
    repeat (5) cyc(1'b0);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL pre_reset_state got %0d exp 3", state); end
    checks++; if (dut.cnt_q !== 8'd1) begin errors++; $display("FAIL pre_reset_cnt got %0d exp 1", dut.cnt_q); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL async_state got %0d exp 0", state); end
    checks++; if (arrow_visible !== 1'b0) begin errors++; $display("FAIL async_vis got %b exp 0", arrow_visible); end
    checks++; if (dut.cnt_q !== 8'd0) begin errors++; $display("FAIL async_cnt got %0d exp 0", dut.cnt_q); end
    #1 rst_n = 1'b1;
    arrow_px = 1'b1;
    #1;
    checks++; if (arrow_on !== 1'b0) begin errors++; $display("FAIL post_reset_arrow_on got %b exp 0", arrow_on); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL post_reset_state got %0d exp 0", state); end
    arrow_px = 1'b0;
    game_over = 1'b0;
    cyc(1'b0);
    // Reset while the restart pulse is high
    enter_wait();
    press();
    frame();
    frame();
    frame();
    checks++; if (restart !== 1'b1) begin errors++; $display("FAIL pre_reset_pulse got %b exp 1", restart); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (restart !== 1'b0) begin errors++; $display("FAIL async_restart got %b exp 0", restart); end
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL async_restart_state got %0d exp 0", state); end
    #1 rst_n = 1'b1;
    game_over = 1'b0;
    cyc(1'b0);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL final_state got %0d exp 0", state); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    game_over  = 1'b0;
    btn        = 1'b0;
    arrow_px   = 1'b0;
    test_reset();
    test_lock_blink();
    test_hold_restart();
    test_hold_release();
    test_game_over_drop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gameover_arrow_ctrl.md
Name: gameover_arrow_ctrl

Overview:
- Sequences the game-over "restart" arrow glyph and the restart request.
- Locks out input for a fixed number of frames after game over, then blinks the arrow while waiting for the player.
- Requires the restart button to be held for a fixed number of frames, then emits a one-cycle restart pulse to game logic.
- Sits between the arrow glyph decoder (pixel hit input) and the VGA colour mux, clocked with the pixel/system clock.

Parameters:
LOCK_FRAMES, 30, frames after game_over rises during which the button is ignored and the arrow is hidden (1..255)
BLINK_FRAMES, 15, frames per blink half-period in WAIT (1..255)
HOLD_FRAMES, 20, frames the button must stay high in HOLD to trigger restart (1..255)

Ports:
clk  in  1  system/pixel clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per video frame (end of vsync)
game_over  in  1  level from game logic; 1 = game lost
btn  in  1  restart button, already synchronised/debounced, active-high
arrow_px  in  1  arrow glyph hit for current x,y
arrow_on  out  1  arrow_px AND arrow_visible, combinational, to colour mux
arrow_visible  out  1  registered arrow enable
restart  out  1  one-cycle restart request
state  out  3  FSM state for debug: PLAY=0, LOCK=1, WAIT=2, HOLD=3, RESTART=4

Behaviour:
- Reset (rst_n=0, async): state=PLAY, arrow_visible=0, restart=0, frame counter=0, blink_phase=1, btn_q=0.
- btn_q <= btn every cycle; rising edge = btn & ~btn_q.
- Single 8-bit frame counter cnt, cleared on every state transition; increments on frame_tick inside LOCK, WAIT and HOLD.
- "Terminal tick" = frame_tick while cnt == PARAM-1.
- PLAY: arrow_visible=0. If game_over=1 -> LOCK.
- LOCK: arrow_visible=0. Button ignored. On terminal tick (LOCK_FRAMES) -> WAIT.
  - Entry to WAIT sets blink_phase=1.
- WAIT: arrow_visible=blink_phase.
  - On terminal tick (BLINK_FRAMES): blink_phase toggles, cnt -> 0, state stays WAIT.
  - On rising edge of btn -> HOLD. Edges are sampled only while in WAIT: a button already high on entry is not a press.
- HOLD: arrow_visible=1 (solid).
  - If btn=0 -> WAIT with blink_phase=1.
  - Else on terminal tick (HOLD_FRAMES) -> RESTART.
  - If btn falls in the same cycle as the terminal tick, release wins -> WAIT.
- RESTART: restart=1 for exactly this one cycle (decoded from the state register, glitch-free); arrow_visible=0. Next cycle -> PLAY unconditionally, even if game_over is still 1.
  - Game logic must drop game_over within one frame. If game_over is still 1 in PLAY, a new LOCK starts; this is accepted behaviour.
- game_over=0 while in LOCK, WAIT or HOLD -> PLAY next cycle, no restart pulse, arrow hidden. This has priority over all other transitions.
- arrow_visible is registered and reflects the state/blink_phase of the same cycle's registers. Update latency from transition to visible change is one clock.
- arrow_on = arrow_px & arrow_visible, with no added latency relative to arrow_px.
- Async reset mid-operation: all registers return to reset values immediately; restart drops at once.
- PARAM=1 behaves as a single-frame wait, i.e. the first frame_tick is terminal.

Test Plan (override LOCK_FRAMES=4, BLINK_FRAMES=2, HOLD_FRAMES=3; frame_tick every 10 clocks):
1. Reset, game_over=0, toggle btn -> state=0, arrow_visible=0, restart never 1.
2. Raise game_over, hold btn=1 throughout -> LOCK for 4 ticks, then WAIT. No HOLD entry because there is no rising edge. arrow_visible pattern per frame: 1,1,0,0,1,1.
3. In WAIT, press btn and keep it high -> HOLD, arrow_visible=1. After 3 ticks, state=4 for one cycle with restart=1, then state=0.
4. In HOLD, release btn after 2 ticks -> back to WAIT, arrow_visible=1 (phase reset), restart stays 0. Release coinciding with the 3rd tick -> WAIT, no pulse.
5. In WAIT and again in HOLD, drop game_over -> state=0 next cycle, arrow_visible=0, restart=0.
6. Assert rst_n=0 asynchronously in HOLD mid-frame -> outputs clear without a clock edge. After release, state=0 and cnt=0; arrow_px=1 gives arrow_on=0.
